// File: rtl/alu_seq_if.sv
// alu_seq_if: groups the fetch, ALU, data-memory and status signals of the
// alu_seq sequencer. The master modport is the sequencer's view, the slave
// modport is the environment (program memory, ALU, data memory).
interface alu_seq_if #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
);
  logic                      run;
  logic                      pm_req;
  logic [PC_WIDTH-1:0]       pm_addr;
  logic                      pm_ack;
  logic [IWIDTH+2+WIDTH-1:0] pm_data;
  logic [IWIDTH-1:0]         alu_op;
  logic [1:0]                alu_src;
  logic [WIDTH-1:0]          alu_imm;
  logic [WIDTH-1:0]          alu_a;
  logic                      alu_c_in;
  logic                      alu_b_in;
  logic [WIDTH-1:0]          alu_out;
  logic                      alu_c_out;
  logic                      alu_b_out;
  logic                      mem_we;
  logic [WIDTH-1:0]          mem_addr;
  logic [WIDTH-1:0]          mem_wdata;
  logic [WIDTH-1:0]          cr;
  logic                      halt;

  modport master (
    input  run, pm_ack, pm_data, alu_out, alu_c_out, alu_b_out,
    output pm_req, pm_addr, alu_op, alu_src, alu_imm, alu_a, alu_c_in,
           alu_b_in, mem_we, mem_addr, mem_wdata, cr, halt
  );

  modport slave (
    output run, pm_ack, pm_data, alu_out, alu_c_out, alu_b_out,
    input  pm_req, pm_addr, alu_op, alu_src, alu_imm, alu_a, alu_c_in,
           alu_b_in, mem_we, mem_addr, mem_wdata, cr, halt
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: fetch/execute sequencer driving an external ALU and data memory.
// Each instruction takes a FETCH (held until pm_ack) and one EXEC cycle.
// Optional feature: define CARRY_CHAIN_EN to keep C/B flags and feed them
// back into ADD/SUB for multi-word arithmetic; without it the flags read 0.
// Assumes PC_WIDTH <= WIDTH (jump targets come from the operand field).
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int IWIDTH   = 8,
  parameter int PC_WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.master bus
);

  localparam int IRW = IWIDTH + 2 + WIDTH;

  localparam logic [IWIDTH-1:0] OP_ALU_LAST = IWIDTH'(8'h11);
  localparam logic [IWIDTH-1:0] OP_ADD      = IWIDTH'(8'h07);
  localparam logic [IWIDTH-1:0] OP_SUB      = IWIDTH'(8'h08);
  localparam logic [IWIDTH-1:0] OP_S        = IWIDTH'(8'h1B);
  localparam logic [IWIDTH-1:0] OP_R        = IWIDTH'(8'h1C);
  localparam logic [IWIDTH-1:0] OP_ST       = IWIDTH'(8'h1D);
  localparam logic [IWIDTH-1:0] OP_STN      = IWIDTH'(8'h1E);
  localparam logic [IWIDTH-1:0] OP_LD       = IWIDTH'(8'h1F);
  localparam logic [IWIDTH-1:0] OP_LDN      = IWIDTH'(8'h20);
  localparam logic [IWIDTH-1:0] OP_JMP      = IWIDTH'(8'h21);
  localparam logic [IWIDTH-1:0] OP_JMPC     = IWIDTH'(8'h22);
  localparam logic [IWIDTH-1:0] OP_HALT     = IWIDTH'(8'hFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Opcodes whose EXEC writes the ALU result into CR.
  function automatic logic f_writes_cr(input logic [IWIDTH-1:0] op);
    return (op <= OP_ALU_LAST) || (op == OP_S) || (op == OP_R) ||
           (op == OP_LD) || (op == OP_LDN);
  endfunction

  // Opcodes that pulse the data-memory write strobe.
  function automatic logic f_is_store(input logic [IWIDTH-1:0] op);
    return (op == OP_ST) || (op == OP_STN);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [IRW-1:0]      r_ir;
  logic [IRW-1:0]      w_ir_nxt;
  logic [WIDTH-1:0]    r_cr;
  logic [WIDTH-1:0]    w_cr_nxt;
  logic                r_pm_req;
  logic                r_mem_we;
  logic                w_mem_we_nxt;
  logic                r_halt;
  logic                w_halt_nxt;
  logic                w_c_flag;
  logic                w_b_flag;
  logic                w_c_nxt;
  logic                w_b_nxt;

  logic [IWIDTH-1:0]   w_op;
  logic [IWIDTH-1:0]   w_fetch_op;
  logic [WIDTH-1:0]    w_opnd;
  logic                w_ack;

  assign w_op       = r_ir[IRW-1 -: IWIDTH];
  assign w_opnd     = r_ir[WIDTH-1:0];
  assign w_fetch_op = bus.pm_data[IRW-1 -: IWIDTH];
  // pm_ack only means something while a request is outstanding.
  assign w_ack      = bus.pm_ack & r_pm_req;

  assign bus.pm_req    = r_pm_req;
  assign bus.pm_addr   = r_pc;
  assign bus.alu_op    = w_op;
  assign bus.alu_src   = r_ir[WIDTH+1:WIDTH];
  assign bus.alu_imm   = w_opnd;
  assign bus.alu_a     = r_cr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = w_opnd;
  assign bus.mem_wdata = bus.alu_out;
  assign bus.cr        = r_cr;
  assign bus.halt      = r_halt;

  // Next-state and datapath update selection for the fetch/execute FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_cr_nxt     = r_cr;
    w_c_nxt      = w_c_flag;
    w_b_nxt      = w_b_flag;
    w_mem_we_nxt = 1'b0;
    w_halt_nxt   = r_halt;
    case (r_state)
      S_IDLE: begin
        if (bus.run) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (w_ack) begin
          w_ir_nxt     = bus.pm_data;
          w_state_nxt  = S_EXEC;
          // Strobe is registered, so it is decided from the fetched word.
          w_mem_we_nxt = f_is_store(w_fetch_op);
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        w_pc_nxt    = r_pc + PC_WIDTH'(1);
        w_state_nxt = bus.run ? S_FETCH : S_IDLE;
        if (f_writes_cr(w_op)) begin
          w_cr_nxt = bus.alu_out;
        end else begin
          w_cr_nxt = r_cr;
        end
        if (w_op == OP_ADD) begin
          w_c_nxt = bus.alu_c_out;
        end else if (w_op == OP_SUB) begin
          w_b_nxt = bus.alu_b_out;
        end else begin
          w_c_nxt = w_c_flag;
        end
        if (w_op == OP_JMP) begin
          w_pc_nxt = w_opnd[PC_WIDTH-1:0];
        end else if ((w_op == OP_JMPC) && (r_cr != '0)) begin
          w_pc_nxt = w_opnd[PC_WIDTH-1:0];
        end else if (w_op == OP_HALT) begin
          w_pc_nxt    = r_pc;
          w_state_nxt = S_HALT;
          w_halt_nxt  = 1'b1;
        end else begin
          w_halt_nxt = r_halt;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, program counter, instruction, result and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_cr     <= '0;
      r_pm_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_cr     <= w_cr_nxt;
      r_pm_req <= (w_state_nxt == S_FETCH);
      r_mem_we <= w_mem_we_nxt;
      r_halt   <= w_halt_nxt;
    end
  end

`ifdef CARRY_CHAIN_EN
  logic r_c;
  logic r_b;

  assign w_c_flag     = r_c;
  assign w_b_flag     = r_b;
  assign bus.alu_c_in = (w_op == OP_ADD) ? r_c : 1'b0;
  assign bus.alu_b_in = (w_op == OP_SUB) ? r_b : 1'b0;

  // Carry/borrow flags kept between instructions for multi-word arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= 1'b0;
      r_b <= 1'b0;
    end else begin
      r_c <= w_c_nxt;
      r_b <= w_b_nxt;
    end
  end
`else
  logic w_unused_flags;

  assign w_c_flag       = 1'b0;
  assign w_b_flag       = 1'b0;
  assign bus.alu_c_in   = 1'b0;
  assign bus.alu_b_in   = 1'b0;
  // Flags are not stored in this build; their next values are discarded.
  assign w_unused_flags = w_c_nxt ^ w_b_nxt ^ bus.alu_c_out ^ bus.alu_b_out;
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
Parameters (name, default, meaning):
REQ-001 WIDTH, 8, datapath word width.
REQ-002 IWIDTH, 8, opcode width.
REQ-003 PC_WIDTH, 8, program counter width.
Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 run  in  1  enables instruction execution.
REQ-007 pm_req  out  1  program-memory fetch request.
REQ-008 pm_addr  out  PC_WIDTH  fetch address, equal to PC.
REQ-009 pm_ack  in  1  fetch data valid.
REQ-010 pm_data  in  IWIDTH+2+WIDTH  instruction: [top IWIDTH] opcode, [next 2] source select, [low WIDTH] operand.
REQ-011 alu_op, alu_src, alu_imm  out  IWIDTH, 2, WIDTH  ALU opcode, operand-B source select and immediate, all driven from IR.
REQ-012 alu_a  out  WIDTH  operand A, always equal to CR.
REQ-013 alu_c_in, alu_b_in  out  1, 1  carry and borrow into the ALU.
REQ-014 alu_out, alu_c_out, alu_b_out  in  WIDTH, 1, 1  ALU result, carry-out and borrow-out.
REQ-015 mem_we, mem_addr, mem_wdata  out  1, WIDTH, WIDTH  data-memory write strobe, address (IR operand) and data.
REQ-016 cr, halt  out  WIDTH, 1  current result register and halted flag.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE: run=1 -> FETCH; otherwise remain in IDLE.
REQ-019 FETCH: pm_req=1 and pm_addr=PC held stable until pm_ack=1; on ack, pm_data latched into IR, next state EXEC.
REQ-020 pm_ack SHALL be ignored while pm_req=0.
REQ-021 EXEC lasts exactly one cycle; ALU result is sampled at the end of EXEC; next state is FETCH if run=1, else IDLE.
REQ-022 Minimum throughput SHALL be 2 cycles per instruction when pm_ack is returned in the same cycle as pm_req.
REQ-023 Arithmetic/logic opcodes 0x00-0x11 and S/R 0x1B/0x1C: CR <= alu_out.
REQ-024 LD/LDN 0x1F/0x20: CR <= alu_out.
REQ-025 ADD 0x07: also updates the C flag from alu_c_out; SUB 0x08: also updates the B flag from alu_b_out; no other opcode changes C or B.
REQ-026 ST/STN 0x1D/0x1E: mem_we=1 for the EXEC cycle only, with mem_wdata=alu_out and mem_addr=IR operand; CR unchanged.
REQ-027 JMP 0x21: PC <= operand[PC_WIDTH-1:0].
REQ-028 JMPC 0x22: PC <= operand when CR != 0; otherwise PC+1.
REQ-029 HALT 0xFF: state goes to HALT and halt=1; HALT is left only by reset.
REQ-030 All other opcodes SHALL act as NOP: PC+1 with no other state change.
REQ-031 PC increments modulo 2^PC_WIDTH, wrapping from all-ones to 0.
REQ-032 run deasserted during FETCH: the fetch and its EXEC still complete, then state goes to IDLE.
REQ-033 mem_we SHALL be 0 in every state except EXEC of ST/STN.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, and PC, IR, CR, C, B, pm_req, mem_we and halt all 0.
REQ-035 Reset during FETCH or EXEC aborts the instruction: no memory write, and pm_req=0 from the next cycle.
REQ-036 rst SHALL take priority over every other input.

Configuration
REQ-037 With CARRY_CHAIN_EN defined: alu_c_in=C during ADD and alu_b_in=B during SUB, enabling multi-word arithmetic.
REQ-038 Without CARRY_CHAIN_EN: alu_c_in and alu_b_in are tied to 0, and the C and B flags are not implemented (read as 0).

Verification
REQ-039 Reset, then run=1 with zero-wait ack: program LD imm 0x05; ADD imm 0x03; ST to 0x10 -> mem_we pulse with addr 0x10 and data 0x08; 6 cycles from the first pm_req.
REQ-040 CARRY_CHAIN_EN: ADD 0xFF+0x01 then ADD 0x00+0x00 -> CR=0x00 with C=1, then CR=0x01.
REQ-041 pm_ack delayed 3 cycles -> pm_addr and pm_req stay stable for 4 cycles, and IR is latched only on the ack cycle.
REQ-042 JMPC with CR=0 at PC=0x04 -> next pm_addr=0x05; with CR=0x01 and operand 0x20 -> next pm_addr=0x20; NOP at PC=0xFF -> next pm_addr=0x00.
REQ-043 HALT opcode -> halt=1 and no further pm_req until rst; rst asserted mid-FETCH -> pm_req=0 the next cycle and PC=0.
